// File: rtl/gamepad_rx_if.sv
// Pin and register-file bundle for the serial gamepad receiver.
// slave is the receiver side; master is whoever drives the pins and reads the results.
interface gamepad_rx_if #(
    parameter int CHANNELS = 2,
    parameter int BITS     = 12
);
    logic                     enable;
    logic                     game_latch;
    logic                     game_clk;
    logic [CHANNELS-1:0]      game_data;
    logic                     err_clr;
    logic [CHANNELS*BITS-1:0] buttons;
    logic [CHANNELS-1:0]      present;
    logic                     update;
    logic                     timeout_err;

    modport master (
        output enable, game_latch, game_clk, game_data, err_clr,
        input  buttons, present, update, timeout_err
    );

    modport slave (
        input  enable, game_latch, game_clk, game_data, err_clr,
        output buttons, present, update, timeout_err
    );
endinterface

// File: rtl/gamepad_rx.sv
// Multi-channel serial gamepad receiver: synchronises the pad pins, captures
// one frame per latch into per-channel shift registers and commits decoded buttons.
//
// state   | meaning
// IDLE    | waiting for a latch edge; game_clk edges ignored
// CAPTURE | shifting one bit per game_clk edge, stall timer running
// COMMIT  | one cycle: publish buttons/present and pulse update
module gamepad_rx #(
    parameter int CHANNELS       = 2,
    parameter int BITS           = 12,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic         clk,
    input logic         rst_n,
    gamepad_rx_if.slave bus
);
    localparam int CNT_W = $clog2(BITS);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITS - 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, COMMIT} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] latch_sync, clk_sync;
    logic [SYNC_STAGES-1:0] data_sync [CHANNELS];
    logic                   latch_prev, clk_prev;
    logic                   latch_rise, clk_rise;
    logic [CHANNELS-1:0]    data_s;

    logic [BITS-1:0]          shift_q [CHANNELS];
    logic [CNT_W-1:0]         bit_cnt;
    logic [TMO_W-1:0]         tmo_cnt;
    logic [CHANNELS*BITS-1:0] buttons_q;
    logic [CHANNELS-1:0]      present_q;
    logic                     update_q, err_q;

    logic clear_frame, do_shift, do_timeout, do_commit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latch_sync <= '0;
            clk_sync   <= '0;
            latch_prev <= 1'b0;
            clk_prev   <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) data_sync[c] <= '0;
        end else begin
            latch_sync <= {latch_sync[SYNC_STAGES-2:0], bus.game_latch};
            clk_sync   <= {clk_sync[SYNC_STAGES-2:0], bus.game_clk};
            latch_prev <= latch_sync[SYNC_STAGES-1];
            clk_prev   <= clk_sync[SYNC_STAGES-1];
            for (int c = 0; c < CHANNELS; c++)
                data_sync[c] <= {data_sync[c][SYNC_STAGES-2:0], bus.game_data[c]};
        end
    end

    assign latch_rise = latch_sync[SYNC_STAGES-1] & ~latch_prev;
    assign clk_rise   = clk_sync[SYNC_STAGES-1] & ~clk_prev;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_data
        assign data_s[g] = data_sync[g][SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // A latch edge always wins over a coincident clock edge.
    always_comb begin
        state_d     = state_q;
        clear_frame = 1'b0;
        do_shift    = 1'b0;
        do_timeout  = 1'b0;
        do_commit   = 1'b0;
        if (!bus.enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (latch_rise) begin
                        clear_frame = 1'b1;
                        state_d     = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (latch_rise) begin
                        clear_frame = 1'b1;
                    end else if (clk_rise) begin
                        do_shift = 1'b1;
                        if (bit_cnt == LAST_BIT) state_d = COMMIT;
                    end else if (tmo_cnt == TMO_W'(1)) begin
                        do_timeout = 1'b1;
                        state_d    = IDLE;
                    end
                end
                COMMIT: begin
                    do_commit = 1'b1;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Stall timer counts down from TIMEOUT_CYCLES-1; terminal count fires the timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            tmo_cnt <= TMO_LOAD;
            for (int c = 0; c < CHANNELS; c++) shift_q[c] <= '0;
        end else if (clear_frame) begin
            bit_cnt <= '0;
            tmo_cnt <= TMO_LOAD;
            for (int c = 0; c < CHANNELS; c++) shift_q[c] <= '0;
        end else if (do_shift) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
            tmo_cnt <= TMO_LOAD;
            for (int c = 0; c < CHANNELS; c++)
                shift_q[c] <= {data_s[c], shift_q[c][BITS-1:1]};
        end else if (state_q == CAPTURE) begin
            tmo_cnt <= tmo_cnt - TMO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buttons_q <= '0;
            present_q <= '0;
            update_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            update_q <= do_commit;
            if (do_commit) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    buttons_q[c*BITS +: BITS] <= ~shift_q[c];
                    present_q[c]              <= ~&shift_q[c];
                end
            end
            if (do_timeout)       err_q <= 1'b1;
            else if (bus.err_clr) err_q <= 1'b0;
        end
    end

    assign bus.buttons     = buttons_q;
    assign bus.present     = present_q;
    assign bus.update      = update_q;
    assign bus.timeout_err = err_q;
endmodule
